// File: rtl/rf_wl_sequencer.sv
// Word-line sequencer: serially shifts a one-hot row into the we/rea/reb chains, holds it,
// then (only when RF_WL_SEQ_CLEAR_EN is defined) shifts zeros through to clear it.
module rf_wl_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_sel,
    input  logic [4:0] cmd_addr_w,
    input  logic [4:0] cmd_addr_a,
    input  logic [4:0] cmd_addr_b,
    output logic       we_data,
    output logic       we_ena,
    output logic       rea_data,
    output logic       rea_ena,
    output logic       reb_data,
    output logic       reb_ena,
    output logic       done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_CLEAR} state_t;

    localparam logic [7:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [4:0] r_k;
    logic [7:0] r_hold;
    logic [2:0] r_sel;
    logic [4:0] r_addr_w;
    logic [4:0] r_addr_a;
    logic [4:0] r_addr_b;
    logic [5:0] r_out;
    logic       r_done;

    state_t     w_post_state;
    logic [5:0] w_post_out;
    logic       w_post_done;

    // Output vector layout: {we_ena, we_data, rea_ena, rea_data, reb_ena, reb_data}
    function automatic logic [5:0] shift_bits(input logic [2:0] sel, input logic [4:0] aw,
                                              input logic [4:0] aa, input logic [4:0] ab,
                                              input logic [4:0] k);
        logic [5:0] b;
        b    = '0;
        b[5] = sel[2];
        b[4] = sel[2] && (k == 5'd31 - aw);
        b[3] = sel[1];
        b[2] = sel[1] && (k == 5'd31 - aa);
        b[1] = sel[0];
        b[0] = sel[0] && (k == 5'd31 - ab);
        return b;
    endfunction

    function automatic logic [5:0] clear_bits(input logic [2:0] sel);
        return {sel[2], 1'b0, sel[1], 1'b0, sel[0], 1'b0};
    endfunction

    // What follows HOLD (or SHIFT when there is no hold time).
`ifdef RF_WL_SEQ_CLEAR_EN
    assign w_post_state = ST_CLEAR;
    assign w_post_out   = clear_bits(r_sel);
    assign w_post_done  = 1'b0;
`else
    assign w_post_state = ST_IDLE;
    assign w_post_out   = '0;
    assign w_post_done  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_hold   <= '0;
            r_sel    <= '0;
            r_addr_w <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_out <= '0;
                    if (cmd_valid) begin
                        r_sel    <= cmd_sel;
                        r_addr_w <= cmd_addr_w;
                        r_addr_a <= cmd_addr_a;
                        r_addr_b <= cmd_addr_b;
                        r_k      <= '0;
                        r_state  <= ST_SHIFT;
                        r_out    <= shift_bits(cmd_sel, cmd_addr_w, cmd_addr_a, cmd_addr_b, 5'd0);
                    end
                end
                ST_SHIFT: begin
                    if (r_k == 5'd31) begin
                        r_k <= '0;
                        if (HOLD_CYCLES != 0) begin
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                            r_out   <= '0;
                        end else begin
                            r_state <= w_post_state;
                            r_out   <= w_post_out;
                            r_done  <= w_post_done;
                        end
                    end else begin
                        r_k   <= r_k + 5'd1;
                        r_out <= shift_bits(r_sel, r_addr_w, r_addr_a, r_addr_b, r_k + 5'd1);
                    end
                end
                ST_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= w_post_state;
                        r_out   <= w_post_out;
                        r_done  <= w_post_done;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                        r_out  <= '0;
                    end
                end
`ifdef RF_WL_SEQ_CLEAR_EN
                ST_CLEAR: begin
                    if (r_k == 5'd31) begin
                        r_k     <= '0;
                        r_state <= ST_IDLE;
                        r_out   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k   <= r_k + 5'd1;
                        r_out <= clear_bits(r_sel);
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign we_ena    = r_out[5];
    assign we_data   = r_out[4];
    assign rea_ena   = r_out[3];
    assign rea_data  = r_out[2];
    assign reb_ena   = r_out[1];
    assign reb_data  = r_out[0];
    assign done      = r_done;

endmodule

// File: tb/tb_rf_wl_sequencer.sv
// Bench for rf_wl_sequencer: table of commands checked via chain models, hand sequences,
// and random traffic against a queue-based per-cycle reference model.
module tb_rf_wl_sequencer;

    localparam int H4 = 4;
`ifdef RF_WL_SEQ_CLEAR_EN
    localparam int CLR = 32;
`else
    localparam int CLR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       v0 = 1'b0;
    logic [2:0] cmd_sel = '0;
    logic [4:0] aw = '0, aa = '0, ab = '0;
    logic       ch_clr = 1'b0;

    logic ready, done, wd, we, ad, ae, bd, be;
    logic ready0, done0, wd0, we0, ad0, ae0, bd0, be0;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wl_sequencer #(.HOLD_CYCLES(H4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready),
        .cmd_sel(cmd_sel), .cmd_addr_w(aw), .cmd_addr_a(aa), .cmd_addr_b(ab),
        .we_data(wd), .we_ena(we), .rea_data(ad), .rea_ena(ae),
        .reb_data(bd), .reb_ena(be), .done(done)
    );

    rf_wl_sequencer #(.HOLD_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(ready0),
        .cmd_sel(cmd_sel), .cmd_addr_w(aw), .cmd_addr_a(aa), .cmd_addr_b(ab),
        .we_data(wd0), .we_ena(we0), .rea_data(ad0), .rea_ena(ae0),
        .reb_data(bd0), .reb_ena(be0), .done(done0)
    );

    // Word-line chains as seen by the array: shift toward higher index when ena is high.
    logic [31:0] ch_w, ch_a, ch_b, ch0_w, ch0_a, ch0_b;
    always @(posedge clk) begin
        if (ch_clr) begin
            ch_w <= '0; ch_a <= '0; ch_b <= '0; ch0_w <= '0; ch0_a <= '0; ch0_b <= '0;
        end else begin
            if (we)  ch_w  <= {ch_w[30:0], wd};
            if (ae)  ch_a  <= {ch_a[30:0], ad};
            if (be)  ch_b  <= {ch_b[30:0], bd};
            if (we0) ch0_w <= {ch0_w[30:0], wd0};
            if (ae0) ch0_a <= {ch0_a[30:0], ad0};
            if (be0) ch0_b <= {ch0_b[30:0], bd0};
        end
    end

    // Reference model: on acceptance, the whole per-cycle output schedule of the command is
    // queued. Entry = {done, we_ena, we_data, rea_ena, rea_data, reb_ena, reb_data}.
    logic [6:0] exp_q[$];
    logic [6:0] exp_cur = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cur = '0;
        end else begin
            if (exp_q.size() == 0 && cmd_valid) begin
                for (int k = 0; k < 32; k++) begin
                    logic [6:0] e;
                    e = '0;
                    e[5] = cmd_sel[2]; e[4] = cmd_sel[2] && (k == 31 - int'(aw));
                    e[3] = cmd_sel[1]; e[2] = cmd_sel[1] && (k == 31 - int'(aa));
                    e[1] = cmd_sel[0]; e[0] = cmd_sel[0] && (k == 31 - int'(ab));
                    exp_q.push_back(e);
                end
                for (int h = 0; h < H4; h++) exp_q.push_back(7'd0);
                for (int c = 0; c < CLR; c++)
                    exp_q.push_back({1'b0, cmd_sel[2], 1'b0, cmd_sel[1], 1'b0, cmd_sel[0], 1'b0});
                exp_q.push_back(7'b1000000);
            end
            if (exp_q.size() != 0) exp_cur = exp_q.pop_front();
            else exp_cur = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [4:0]  w, a, b;
        logic [31:0] ew, ea, eb;
    } vec_t;

    task automatic run_cmd(input vec_t v, input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 300) begin @(negedge clk); n++; end
        chk($sformatf("v%0d_idle", idx), 32'(ready), 32'd1);
        ch_clr = 1'b1;
        @(negedge clk);
        ch_clr = 1'b0;
        cmd_sel = v.sel; aw = v.w; aa = v.a; ab = v.b; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_sel = 3'($urandom); aw = 5'($urandom); aa = 5'($urandom); ab = 5'($urandom);
        repeat (32) @(posedge clk);
        #1;
        chk($sformatf("v%0d_we_chain", idx), ch_w, v.ew);
        chk($sformatf("v%0d_rea_chain", idx), ch_a, v.ea);
        chk($sformatf("v%0d_reb_chain", idx), ch_b, v.eb);
        n = 32;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        // Accept cycle counts as cycle 1, so done sits (latency - 1) edges after the accept edge.
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(32 + H4 + CLR));
    endtask

    vec_t vecs[6];

    initial begin
        int n, cnt;
        #200000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt;
        vecs[0] = '{3'b100, 5'd0,  5'd0,  5'd0,  32'h1,       32'h0,       32'h0};
        vecs[1] = '{3'b011, 5'd0,  5'd31, 5'd5,  32'h0,       32'h80000000, 32'h20};
        vecs[2] = '{3'b111, 5'd7,  5'd12, 5'd19, 32'h80,      32'h1000,    32'h80000};
        vecs[3] = '{3'b000, 5'd9,  5'd9,  5'd9,  32'h0,       32'h0,       32'h0};
        vecs[4] = '{3'b010, 5'd31, 5'd0,  5'd31, 32'h0,       32'h1,       32'h0};
        vecs[5] = '{3'b101, 5'd16, 5'd3,  5'd1,  32'h10000,   32'h0,       32'h2};

        fork
            forever begin
                @(negedge clk);
                if (rst_n)
                    chk("cycle_outputs", 32'({ready, done, we, wd, ae, ad, be, bd}),
                        32'({exp_q.size() == 0, exp_cur}));
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({done, we, wd, ae, ad, be, bd}), 32'd0);
        chk("reset_outs0", 32'({done0, we0, wd0, ae0, ad0, be0, bd0}), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'({ready, ready0}), 32'd3);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i], i);

        // cmd_valid held high: next command accepted in the done cycle
        @(negedge clk);
        cmd_sel = 3'b110; aw = 5'd4; aa = 5'd8; ab = 5'd2; cmd_valid = 1'b1;
        n = 0;
        while (n < 300) begin @(posedge clk); #1; n++; if (done) break; end
        chk("b2b_done_ready", 32'({done, ready}), 32'd3);
        @(posedge clk); #1;
        chk("b2b_reaccept", 32'({ready, done, we}), 32'b001);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!ready && n < 300) begin @(negedge clk); n++; end

        // reset in the middle of SHIFT at k=10
        @(negedge clk);
        cmd_sel = 3'b111; aw = 5'd21; aa = 5'd0; ab = 5'd0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("k10_we_data", 32'({we, wd}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_outs", 32'({done, we, wd, ae, ad, be, bd}), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        cnt = 0;
        repeat (100) begin @(negedge clk); if (done) cnt++; end
        chk("rst_no_done", 32'(cnt), 32'd0);

        // HOLD_CYCLES = 0 instance
        ch_clr = 1'b1;
        @(negedge clk);
        ch_clr = 1'b0;
        cmd_sel = 3'b111; aw = 5'd3; aa = 5'd17; ab = 5'd30; v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        cmd_sel = 3'($urandom); aw = 5'($urandom); aa = 5'($urandom); ab = 5'($urandom);
        n = 0;
        while (!done0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("h0_latency", 32'(n), 32'(32 + CLR));
        chk("h0_ready", 32'(ready0), 32'd1);
        chk("h0_we_chain",  ch0_w, (CLR != 0) ? 32'h0 : 32'h8);
        chk("h0_rea_chain", ch0_a, (CLR != 0) ? 32'h0 : 32'h20000);
        chk("h0_reb_chain", ch0_b, (CLR != 0) ? 32'h0 : 32'h40000000);

        // random traffic; every cycle compared against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(3) != 0);
            cmd_sel = 3'($urandom); aw = 5'($urandom); aa = 5'($urandom); ab = 5'($urandom);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
